// File: rtl/sram_fifo_ctrl_if.sv
// Valid/ready stream bundle used on both the upstream and downstream sides
// of sram_fifo_ctrl.
interface sram_fifo_ctrl_if #(
    parameter int DATA_WIDTH = 88
);
    logic                  valid;
    logic                  ready;
    logic [DATA_WIDTH-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/sram_fifo_ctrl.sv
// Streaming FIFO controller in front of a simple-dual-port SRAM; a 2-entry
// output buffer absorbs the SRAM's registered read latency (first-word-fall-through).
module sram_fifo_ctrl #(
    parameter int DATA_WIDTH = 88,
    parameter int ADDR_WIDTH = 10,
    parameter int RAM_DEPTH  = 1024
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    sram_fifo_ctrl_if.slave       i_in,
    sram_fifo_ctrl_if.master      o_out,
    output logic [ADDR_WIDTH+1:0] o_fifo_count,
    output logic                  o_sram_wr_cen,
    output logic [ADDR_WIDTH-1:0] o_sram_wr_a,
    output logic [DATA_WIDTH-1:0] o_sram_wr_d,
    output logic                  o_sram_rd_cen,
    output logic [ADDR_WIDTH-1:0] o_sram_rd_a,
    input  logic [DATA_WIDTH-1:0] i_sram_rd_q
);
    localparam int                    CW       = ADDR_WIDTH + 2;
    localparam logic [ADDR_WIDTH:0]   FULL_CNT = (ADDR_WIDTH+1)'(RAM_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_A   = ADDR_WIDTH'(RAM_DEPTH - 1);

    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_sram_cnt;
    logic                  r_rd_pend;
    logic [DATA_WIDTH-1:0] r_ob [2];
    logic                  r_ob_head;
    logic [1:0]            r_ob_cnt;
    logic [CW-1:0]         r_fifo_count;

    logic                  w_in_ready;
    logic                  w_out_valid;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_issue;
    logic [2:0]            w_ob_load;
    logic                  w_ob_tail;
    logic [ADDR_WIDTH:0]   w_sram_cnt_nxt;
    logic [1:0]            w_ob_cnt_nxt;
    logic [CW-1:0]         w_fifo_count_nxt;

    assign w_in_ready  = ~i_rst & (r_sram_cnt != FULL_CNT);
    assign w_out_valid = ~i_rst & (r_ob_cnt != 2'd0);
    assign w_push      = i_in.valid & w_in_ready;
    assign w_pop       = w_out_valid & o_out.ready;

    // Count what the buffer will hold once the in-flight read lands; a pop this
    // cycle frees a slot, hence the combinational dependence on out_ready.
    assign w_ob_load = {1'b0, r_ob_cnt} + {2'b00, r_rd_pend};
    assign w_issue   = ~i_rst & (r_sram_cnt != '0) & (w_ob_load < (3'd2 + {2'b00, w_pop}));

    assign w_ob_tail = r_ob_head ^ r_ob_cnt[0];

    always_comb begin
        w_sram_cnt_nxt = r_sram_cnt;
        if (w_push && !w_issue) begin
            w_sram_cnt_nxt = r_sram_cnt + 1'b1;
        end else if (!w_push && w_issue) begin
            w_sram_cnt_nxt = r_sram_cnt - 1'b1;
        end

        w_ob_cnt_nxt = r_ob_cnt;
        if (r_rd_pend && !w_pop) begin
            w_ob_cnt_nxt = r_ob_cnt + 1'b1;
        end else if (!r_rd_pend && w_pop) begin
            w_ob_cnt_nxt = r_ob_cnt - 1'b1;
        end

        w_fifo_count_nxt = CW'(w_sram_cnt_nxt) + CW'(w_issue) + CW'(w_ob_cnt_nxt);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_sram_cnt   <= '0;
            r_rd_pend    <= 1'b0;
            r_ob_head    <= 1'b0;
            r_ob_cnt     <= 2'd0;
            r_fifo_count <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == LAST_A) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_issue) begin
                r_rd_ptr <= (r_rd_ptr == LAST_A) ? '0 : r_rd_ptr + 1'b1;
            end
            if (w_pop) begin
                r_ob_head <= ~r_ob_head;
            end
            r_sram_cnt   <= w_sram_cnt_nxt;
            r_rd_pend    <= w_issue;
            r_ob_cnt     <= w_ob_cnt_nxt;
            r_fifo_count <= w_fifo_count_nxt;
        end
    end

    // Buffer storage carries no reset; validity is tracked by r_ob_cnt alone.
    always_ff @(posedge i_clk) begin
        if (r_rd_pend && !i_rst) begin
            r_ob[w_ob_tail] <= i_sram_rd_q;
        end
    end

    assign i_in.ready    = w_in_ready;
    assign o_out.valid   = w_out_valid;
    assign o_out.data    = r_ob[r_ob_head];
    assign o_fifo_count  = r_fifo_count;
    assign o_sram_wr_cen = ~w_push;
    assign o_sram_wr_a   = r_wr_ptr;
    assign o_sram_wr_d   = i_in.data;
    assign o_sram_rd_cen = ~w_issue;
    assign o_sram_rd_a   = r_rd_ptr;
endmodule
